sub_parser_array: RTL and testbench

SUB_PARSER_ARRAY -- requirements
Module: sub_parser_array

---
 rtl/sub_parser_array_pkg.sv | 32 +++
 rtl/sub_parser_lane.sv | 59 +++++
 rtl/sub_parser_array.sv | 161 ++++++++++++++++
 tb/tb_sub_parser_array.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sub_parser_array_pkg.sv
// Shared parser definitions: action field layout, size codes and default widths.
package sub_parser_array_pkg;

  localparam int PARSE_ACT_LEN_DEF = 24;
  localparam int VAL_OUT_LEN_DEF   = 48;

  localparam int ACT_EN_BIT   = 0;
  localparam int ACT_SEQ_LSB  = 1;
  localparam int ACT_SEQ_W    = 6;
  localparam int ACT_SIZE_LSB = 7;
  localparam int ACT_SIZE_W   = 2;
  localparam int ACT_OFF_LSB  = 9;
  localparam int ACT_OFF_W    = 9;

  typedef enum logic [1:0] {
    SZ_NONE = 2'b00,
    SZ_2B   = 2'b01,
    SZ_4B   = 2'b10,
    SZ_6B   = 2'b11
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Size code to extracted width in bits (code * 16).
  function automatic logic [7:0] size_bits(input logic [1:0] sz);
    return {2'b00, sz, 4'b0000};
  endfunction

endpackage

// File: rtl/sub_parser_lane.sv
// One extraction lane: decodes a parse action and pulls 2/4/6 bytes out of the header.
module sub_parser_lane
  import sub_parser_array_pkg::*;
#(
  parameter int PKTS_HDR_LEN  = 32*64+256,
  parameter int PARSE_ACT_LEN = PARSE_ACT_LEN_DEF,
  parameter int VAL_OUT_LEN   = VAL_OUT_LEN_DEF
) (
  input  logic [PKTS_HDR_LEN-1:0]  hdr_i,
  input  logic [PARSE_ACT_LEN-1:0] act_i,
  output logic [VAL_OUT_LEN-1:0]   value_o,
  output logic [1:0]               type_o,
  output logic [ACT_SEQ_W-1:0]     seq_o,
  output logic                     valid_o,
  output logic                     err_o
);

  logic                    en;
  logic [1:0]              size;
  logic [ACT_SEQ_W-1:0]    seq;
  logic [ACT_OFF_W-1:0]    off;
  logic                    active;
  logic                    range_err;
  logic [31:0]             end_bit;
  logic [PKTS_HDR_LEN-1:0] shifted;
  logic [VAL_OUT_LEN-1:0]  mask;
  logic                    unused_bits;

  assign en   = act_i[ACT_EN_BIT];
  assign seq  = act_i[ACT_SEQ_LSB +: ACT_SEQ_W];
  assign size = act_i[ACT_SIZE_LSB +: ACT_SIZE_W];
  assign off  = act_i[ACT_OFF_LSB +: ACT_OFF_W];

  assign active    = en && (size != SZ_NONE);
  assign end_bit   = {20'd0, off, 3'b000} + {24'd0, size_bits(size)};
  assign range_err = end_bit > 32'(PKTS_HDR_LEN);
  assign shifted   = hdr_i >> {off, 3'b000};
  assign mask      = ~({VAL_OUT_LEN{1'b1}} << size_bits(size));

  assign unused_bits = ^{act_i[PARSE_ACT_LEN-1:ACT_OFF_LSB+ACT_OFF_W],
                         shifted[PKTS_HDR_LEN-1:VAL_OUT_LEN]};

  always_comb begin
    value_o = '0;
    type_o  = '0;
    seq_o   = '0;
    valid_o = 1'b0;
    err_o   = 1'b0;
    if (active) begin
      valid_o = 1'b1;
      type_o  = size;
      seq_o   = seq;
      err_o   = range_err;
      // An extraction running past the header end reports err and a zero value.
      if (!range_err) value_o = shifted[VAL_OUT_LEN-1:0] & mask;
    end
  end

endmodule

// File: rtl/sub_parser_array.sv
// Captures one header plus its action list, then streams LANES extractions per beat
// through a single output register with valid/ready backpressure.
module sub_parser_array
  import sub_parser_array_pkg::*;
#(
  parameter int PKTS_HDR_LEN  = 32*64+256,
  parameter int PARSE_ACT_LEN = PARSE_ACT_LEN_DEF,
  parameter int VAL_OUT_LEN   = VAL_OUT_LEN_DEF,
  parameter int NUM_ACTS      = 10,
  parameter int LANES         = 2
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PKTS_HDR_LEN-1:0]       pkts_hdr,
  input  logic [NUM_ACTS*PARSE_ACT_LEN-1:0] parse_acts,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*VAL_OUT_LEN-1:0]  val_out,
  output logic [LANES-1:0]              val_out_lane_valid,
  output logic [LANES*2-1:0]            val_out_type,
  output logic [LANES*ACT_SEQ_W-1:0]    val_out_seq,
  output logic [LANES-1:0]              val_out_err,
  output logic                          out_last
);

  localparam int BEATS  = (NUM_ACTS + LANES - 1) / LANES;
  localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BEAT_W = LANES * PARSE_ACT_LEN;
  localparam int ACTS_W = NUM_ACTS * PARSE_ACT_LEN;
  localparam int PAD_W  = BEATS * BEAT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       in_ready_q;
  logic [PKTS_HDR_LEN-1:0]    hdr_q;
  logic [ACTS_W-1:0]          acts_q;

  logic                       out_valid_q, out_last_q;
  logic [LANES*VAL_OUT_LEN-1:0] val_q;
  logic [LANES-1:0]           lane_valid_q, err_q;
  logic [LANES*2-1:0]         type_q;
  logic [LANES*ACT_SEQ_W-1:0] seq_q;

  logic                       accept, load;
  logic [PAD_W-1:0]           acts_pad;
  logic [BEAT_W-1:0]          beat_acts;
  logic [LANES*VAL_OUT_LEN-1:0] beat_val;
  logic [LANES-1:0]           beat_lv, beat_err;
  logic [LANES*2-1:0]         beat_type;
  logic [LANES*ACT_SEQ_W-1:0] beat_seq;

  assign accept = (state_q == ST_IDLE) && in_valid && in_ready_q;
  assign load   = (state_q == ST_RUN) && (!out_valid_q || out_ready);

  // Zero-padding the action list makes lanes past NUM_ACTS decode as inactive.
  assign acts_pad  = PAD_W'(acts_q);
  assign beat_acts = acts_pad[int'(idx_q)*BEAT_W +: BEAT_W];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sub_parser_lane #(
      .PKTS_HDR_LEN (PKTS_HDR_LEN),
      .PARSE_ACT_LEN(PARSE_ACT_LEN),
      .VAL_OUT_LEN  (VAL_OUT_LEN)
    ) u_lane (
      .hdr_i  (hdr_q),
      .act_i  (beat_acts[l*PARSE_ACT_LEN +: PARSE_ACT_LEN]),
      .value_o(beat_val[l*VAL_OUT_LEN +: VAL_OUT_LEN]),
      .type_o (beat_type[l*2 +: 2]),
      .seq_o  (beat_seq[l*ACT_SEQ_W +: ACT_SEQ_W]),
      .valid_o(beat_lv[l]),
      .err_o  (beat_err[l])
    );
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RUN;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        if (load) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      in_ready_q <= (state_d == ST_IDLE);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      hdr_q  <= '0;
      acts_q <= '0;
    end else if (accept) begin
      hdr_q  <= pkts_hdr;
      acts_q <= parse_acts;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      val_q        <= '0;
      lane_valid_q <= '0;
      type_q       <= '0;
      seq_q        <= '0;
      err_q        <= '0;
    end else if (load) begin
      out_valid_q  <= 1'b1;
      out_last_q   <= (idx_q == LAST_IDX);
      val_q        <= beat_val;
      lane_valid_q <= beat_lv;
      type_q       <= beat_type;
      seq_q        <= beat_seq;
      err_q        <= beat_err;
    end else if (out_ready) begin
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      val_q        <= '0;
      lane_valid_q <= '0;
      type_q       <= '0;
      seq_q        <= '0;
      err_q        <= '0;
    end
  end

  assign in_ready           = in_ready_q;
  assign out_valid          = out_valid_q;
  assign out_last           = out_last_q;
  assign val_out            = val_q;
  assign val_out_lane_valid = lane_valid_q;
  assign val_out_type       = type_q;
  assign val_out_seq        = seq_q;
  assign val_out_err        = err_q;

endmodule

// File: tb/tb_sub_parser_array.sv
// Directed bench for sub_parser_array: a 10-action instance and a 3-action instance
// sharing clock and reset.
module tb_sub_parser_array;

  localparam int HDR_LEN = 2304;
  localparam int ACT_LEN = 24;
  localparam int VAL_LEN = 48;
  localparam int LANES   = 2;

  logic clk = 1'b0;
  logic aresetn = 1'b1;
  always #5 clk = ~clk;

  logic                     in_valid, in_ready, out_valid, out_ready, out_last;
  logic [HDR_LEN-1:0]       pkts_hdr;
  logic [10*ACT_LEN-1:0]    parse_acts;
  logic [LANES*VAL_LEN-1:0] val_out;
  logic [LANES-1:0]         lv, err;
  logic [2*LANES-1:0]       ty;
  logic [6*LANES-1:0]       sq;

  logic                     in_valid_p, in_ready_p, out_valid_p, out_ready_p, out_last_p;
  logic [HDR_LEN-1:0]       pkts_hdr_p;
  logic [3*ACT_LEN-1:0]     parse_acts_p;
  logic [LANES*VAL_LEN-1:0] val_out_p;
  logic [LANES-1:0]         lv_p, err_p;
  logic [2*LANES-1:0]       ty_p;
  logic [6*LANES-1:0]       sq_p;

  sub_parser_array #(.PKTS_HDR_LEN(HDR_LEN), .NUM_ACTS(10), .LANES(LANES)) dut (
    .clk(clk), .aresetn(aresetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .pkts_hdr(pkts_hdr), .parse_acts(parse_acts),
    .out_valid(out_valid), .out_ready(out_ready),
    .val_out(val_out), .val_out_lane_valid(lv), .val_out_type(ty),
    .val_out_seq(sq), .val_out_err(err), .out_last(out_last)
  );

  sub_parser_array #(.PKTS_HDR_LEN(HDR_LEN), .NUM_ACTS(3), .LANES(LANES)) dut3 (
    .clk(clk), .aresetn(aresetn),
    .in_valid(in_valid_p), .in_ready(in_ready_p),
    .pkts_hdr(pkts_hdr_p), .parse_acts(parse_acts_p),
    .out_valid(out_valid_p), .out_ready(out_ready_p),
    .val_out(val_out_p), .val_out_lane_valid(lv_p), .val_out_type(ty_p),
    .val_out_seq(sq_p), .val_out_err(err_p), .out_last(out_last_p)
  );

  int checks = 0;
  int failures = 0;

  logic [ACT_LEN-1:0]    acts [10];
  logic [47:0]           e_val[10];
  logic                  e_vld[10];
  logic                  e_err[10];
  logic [1:0]            e_ty [10];
  logic [5:0]            e_sq [10];
  logic [HDR_LEN-1:0]    hdr_pat;
  logic [10*ACT_LEN-1:0] acts_vec;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [ACT_LEN-1:0] mk_act(input logic en, input logic [5:0] seq,
                                                input logic [1:0] size, input logic [8:0] off);
    return {6'd0, off, size, seq, en};
  endfunction

  task automatic check_beat(input string nm, input int b, input int nacts, input int nbeats,
                            input logic ov, input logic ol, input logic [95:0] v,
                            input logic [1:0] lv_i, input logic [1:0] er_i,
                            input logic [3:0] ty_i, input logic [11:0] sq_i);
    chk($sformatf("%s_b%0d_out_valid", nm, b), 64'(ov), 64'd1);
    chk($sformatf("%s_b%0d_out_last", nm, b), 64'(ol), 64'(b == nbeats - 1));
    for (int l = 0; l < LANES; l++) begin
      int          i;
      logic        xv, xe;
      logic [1:0]  xt;
      logic [5:0]  xs;
      logic [47:0] xval;
      i = b*LANES + l;
      xv = 1'b0; xe = 1'b0; xt = 2'd0; xs = 6'd0; xval = 48'd0;
      if (i < nacts) begin
        xv = e_vld[i]; xe = e_err[i]; xt = e_ty[i]; xs = e_sq[i]; xval = e_val[i];
      end
      chk($sformatf("%s_b%0d_l%0d_valid", nm, b, l), 64'(lv_i[l]), 64'(xv));
      chk($sformatf("%s_b%0d_l%0d_err", nm, b, l), 64'(er_i[l]), 64'(xe));
      chk($sformatf("%s_b%0d_l%0d_type", nm, b, l), 64'(ty_i[l*2 +: 2]), 64'(xt));
      chk($sformatf("%s_b%0d_l%0d_seq", nm, b, l), 64'(sq_i[l*6 +: 6]), 64'(xs));
      chk($sformatf("%s_b%0d_l%0d_value", nm, b, l), 64'(v[l*48 +: 48]), 64'(xval));
    end
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({nm, "_out_last"}, 64'(out_last), 64'd0);
    chk({nm, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({nm, "_val_out"}, 64'(|val_out), 64'd0);
    chk({nm, "_lane_valid"}, 64'(lv), 64'd0);
    chk({nm, "_type"}, 64'(ty), 64'd0);
    chk({nm, "_seq"}, 64'(sq), 64'd0);
    chk({nm, "_err"}, 64'(err), 64'd0);
  endtask

  task automatic beat_full(input string nm, input int b);
    check_beat(nm, b, 10, 5, out_valid, out_last, val_out, lv, err, ty, sq);
  endtask

  initial begin
    for (int k = 0; k < HDR_LEN/8; k++) hdr_pat[k*8 +: 8] = 8'(k);

    // en, seq, size, offset; expected value hand-derived from byte k = k mod 256
    acts[0] = mk_act(1'b1, 6'd3,  2'b01, 9'd4);   e_val[0] = 48'h0504;
    acts[1] = mk_act(1'b1, 6'd5,  2'b10, 9'd16);  e_val[1] = 48'h13121110;
    acts[2] = mk_act(1'b1, 6'd7,  2'b11, 9'd100); e_val[2] = 48'h696867666564;
    acts[3] = mk_act(1'b0, 6'd9,  2'b01, 9'd8);   e_val[3] = 48'h0;
    acts[4] = mk_act(1'b1, 6'd10, 2'b00, 9'd8);   e_val[4] = 48'h0;
    acts[5] = mk_act(1'b1, 6'd63, 2'b11, 9'd511); e_val[5] = 48'h0;
    acts[6] = mk_act(1'b1, 6'd1,  2'b01, 9'd286); e_val[6] = 48'h1F1E;
    acts[7] = mk_act(1'b1, 6'd2,  2'b01, 9'd287); e_val[7] = 48'h0;
    acts[8] = mk_act(1'b1, 6'd4,  2'b11, 9'd282); e_val[8] = 48'h1F1E1D1C1B1A;
    acts[9] = mk_act(1'b1, 6'd0,  2'b10, 9'd0);   e_val[9] = 48'h03020100;
    e_vld = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    e_err = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    e_ty  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd3, 2'd2};
    e_sq  = '{6'd3, 6'd5, 6'd7, 6'd0, 6'd0, 6'd63, 6'd1, 6'd2, 6'd4, 6'd0};
    for (int i = 0; i < 10; i++) acts_vec[i*ACT_LEN +: ACT_LEN] = acts[i];

    in_valid = 1'b0; out_ready = 1'b1; pkts_hdr = '0; parse_acts = '0;
    in_valid_p = 1'b0; out_ready_p = 1'b1; pkts_hdr_p = '0; parse_acts_p = '0;

    // Reset
    #2 aresetn = 1'b0;
    #3 check_all_zero("rst");
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // Full array, out_ready held high; inputs scrambled during RUN
    pkts_hdr = hdr_pat; parse_acts = acts_vec; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("e0_in_ready", 64'(in_ready), 64'd0);
    chk("e0_out_valid", 64'(out_valid), 64'd0);
    in_valid = 1'b0; pkts_hdr = '1; parse_acts = '1;
    for (int b = 0; b < 5; b++) begin
      @(posedge clk); #1;
      beat_full("full", b);
      chk($sformatf("full_b%0d_in_ready", b), 64'(in_ready), 64'(b == 4));
    end
    // Next header offered immediately: one header per BEATS+1 cycles
    pkts_hdr = hdr_pat; parse_acts = acts_vec; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("full_drain_out_valid", 64'(out_valid), 64'd0);
    chk("bp_accept_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;

    // Backpressure at beat 2
    for (int b = 0; b < 3; b++) begin
      @(posedge clk); #1;
      beat_full("bp", b);
    end
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      beat_full($sformatf("bp_hold%0d", c), 2);
    end
    out_ready = 1'b1;
    for (int b = 3; b < 5; b++) begin
      @(posedge clk); #1;
      beat_full("bp", b);
    end
    @(posedge clk); #1;
    chk("bp_drain_out_valid", 64'(out_valid), 64'd0);

    // Padding: 3 actions over 2 lanes
    pkts_hdr_p = hdr_pat;
    for (int i = 0; i < 3; i++) parse_acts_p[i*ACT_LEN +: ACT_LEN] = acts[i];
    in_valid_p = 1'b1;
    @(posedge clk); #1;
    in_valid_p = 1'b0;
    for (int b = 0; b < 2; b++) begin
      @(posedge clk); #1;
      check_beat("pad", b, 3, 2, out_valid_p, out_last_p, val_out_p, lv_p, err_p, ty_p, sq_p);
    end
    chk("pad_in_ready", 64'(in_ready_p), 64'd1);

    // Mid-run reset at beat 1
    pkts_hdr = hdr_pat; parse_acts = acts_vec; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      @(posedge clk); #1;
      beat_full("mr", b);
    end
    aresetn = 1'b0;
    #1 check_all_zero("mr_rst");
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(posedge clk); #1;
    chk("mr_after_out_valid", 64'(out_valid), 64'd0);
    chk("mr_after_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    beat_full("mr_fresh", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
